// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and the UART transmitter:
//   - DATA_BITS  : payload width of one character
//   - IDLE_LEVEL : line level while no frame is in flight (also the start-bit
//                  detection reference)
//   - uart_state_e : receiver frame-sequencing states
//   - even_parity  : parity bit value that makes the total count of ones even
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
      ,PARITY = 3'd4
`endif
   } uart_state_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter
// Bit-period timer for the UART receiver. A down-counter reloads to
// CLKS_PER_BIT-1 on restart and on terminal count, so full_tick repeats every
// CLKS_PER_BIT cycles after a restart and half_tick marks the mid-point of the
// first period (CLKS_PER_BIT/2 cycles after restart, integer division).
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   restart   in   reload the counter; first period starts next cycle
//   half_tick out  CLKS_PER_BIT/2 cycles have elapsed since restart
//   full_tick out  terminal count; one bit period has elapsed
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic half_tick,
   output logic full_tick
);

   localparam logic [15:0] RELOAD   = 16'(CLKS_PER_BIT - 1);
   // Counter value reached exactly CLKS_PER_BIT/2 cycles after a reload.
   localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - 16'd1;
      if (restart || cnt_q == 16'd0) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign half_tick = (cnt_q == HALF_CNT);
   assign full_tick = (cnt_q == 16'd0);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receiver with a two-flop input synchronizer, mid-bit sampling,
// start-bit glitch rejection, a ready/ack output handshake, frame-error pulse
// and a sticky overrun flag.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and the stop bit, plus the parity_err output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a synchronized high-to-low edge
// START  | waiting half a bit to confirm the start bit is still low
// DATA   | sampling 8 data bits, LSB first, one per bit period
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; deliver byte or flag frame error
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   serial_in   in   asynchronous serial line, idles high
//   data_out    out  last received byte
//   byte_ready  out  data_out holds an unconsumed byte
//   byte_ack    in   consumer acknowledge, clears byte_ready
//   frame_err   out  one-cycle pulse on a low stop bit
//   overrun     out  sticky: a byte completed while byte_ready was high
//   parity_err  out  one-cycle pulse on parity mismatch (UART_RX_PARITY_EN)
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 byte_ready,
   input  logic                 byte_ack,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,output logic                parity_err
`endif
);

   localparam int BIT_CNT_W = $clog2(DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   uart_state_e state_q, state_d;

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 rx_prev_q, rx_prev_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 byte_ready_q, byte_ready_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err_q, parity_err_d;
`endif

   logic rx;
   logic baud_restart;
   logic half_tick;
   logic full_tick;

   assign rx = sync2_q;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .restart   (baud_restart),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sync1_q      <= IDLE_LEVEL;
         sync2_q      <= IDLE_LEVEL;
         rx_prev_q    <= IDLE_LEVEL;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         byte_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         rx_prev_q    <= rx_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         byte_ready_q <= byte_ready_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      sync1_d      = serial_in;
      sync2_d      = sync1_q;
      rx_prev_d    = sync2_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      byte_ready_d = byte_ready_q;
      frame_err_d  = 1'b0;
      overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      baud_restart = 1'b0;

      if (byte_ack && byte_ready_q) begin
         byte_ready_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // Edge, not level: a line stuck low after a bad frame must go
            // high again before another frame can start.
            if (rx_prev_q == IDLE_LEVEL && rx != IDLE_LEVEL) begin
               state_d      = START;
               bit_cnt_d    = '0;
               baud_restart = 1'b1;
            end
         end

         START: begin
            if (half_tick) begin
               if (rx != IDLE_LEVEL) begin
                  // Re-align the timer to mid-start so data samples land mid-bit.
                  state_d      = DATA;
                  baud_restart = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         DATA: begin
            if (full_tick) begin
               shift_d = {rx, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (full_tick) begin
               if (rx != even_parity(shift_q)) begin
                  parity_err_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  state_d = STOP;
               end
            end
         end
`endif

         STOP: begin
            if (full_tick) begin
               state_d = IDLE;
               if (rx == 1'b1) begin
                  data_out_d   = shift_q;
                  byte_ready_d = 1'b1;
                  if (byte_ready_q && !byte_ack) begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_out   = data_out_q;
   assign byte_ready = byte_ready_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Scoreboard bench for uart_receiver. The stimulus process decides, from the
// frame it is about to put on the line, which single event the receiver must
// report (byte delivered, frame error, parity error, or nothing) and queues it.
// An independent monitor watches the outputs on falling clock edges and pops
// and compares one expectation per reported event. Handshake state
// (byte_ready / overrun) is tracked with a small flag model.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and parity_err).
module tb_uart_receiver;

   localparam int N = 16;

   localparam logic [1:0] K_BYTE = 2'd0;
   localparam logic [1:0] K_FERR = 2'd1;
   localparam logic [1:0] K_PERR = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       byte_ack;
   logic [7:0] data_out;
   logic       byte_ready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_bad_next = 1'b0;
`endif

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic       model_ready;
   logic       model_overrun;
   logic [7:0] last_data;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .byte_ready (byte_ready),
      .byte_ack   (byte_ack),
      .frame_err  (frame_err),
      .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
      ,.parity_err (parity_err)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Puts one complete frame on the line, starting and ending at a falling
   // edge. rst_bit >= 0 pulses reset part-way through that data bit, in which
   // case the frame is expected to produce nothing.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
      logic par_bit;
      par_bit = ^b;
      if (rst_bit < 0) begin
`ifdef UART_RX_PARITY_EN
         if (par_bad_next) push_exp(K_PERR, b);
         else
`endif
         if (!stop_bit) push_exp(K_FERR, b);
         else push_exp(K_BYTE, b);
      end
`ifdef UART_RX_PARITY_EN
      if (par_bad_next) par_bit = ~par_bit;
`endif
      serial_in = 1'b0;
      idle(N);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         if (i == rst_bit) begin
            idle(3);
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            idle(N - 4);
         end else begin
            idle(N);
         end
      end
`ifdef UART_RX_PARITY_EN
      serial_in = par_bit;
      idle(N);
`else
      if (par_bit === 1'bx) serial_in = 1'b1;
`endif
      serial_in = stop_bit;
      idle(N);
      serial_in = 1'b1;
   endtask

   task automatic ack_pulse();
      byte_ack = 1'b1;
      idle(1);
      byte_ack = 1'b0;
      idle(1);
   endtask

   // Monitor: one expectation consumed per event the DUT reports.
   initial begin : monitor
      logic       ready_prev;
      logic [7:0] data_prev;
      exp_t       e;
      ready_prev = 1'b0;
      data_prev  = 8'h00;
      forever begin
         @(negedge clk);
         if (frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame_err: got pulse, required no event");
            end else begin
               e = exp_q.pop_front();
               check("ferr_kind", 32'(K_FERR), 32'(e.kind));
               check("ferr_ready_kept", 32'(byte_ready), 32'(ready_prev));
               check("ferr_data_kept", 32'(data_out), 32'(data_prev));
            end
         end
`ifdef UART_RX_PARITY_EN
         if (parity_err === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_parity_err: got pulse, required no event");
            end else begin
               e = exp_q.pop_front();
               check("perr_kind", 32'(K_PERR), 32'(e.kind));
               check("perr_ready_kept", 32'(byte_ready), 32'(ready_prev));
            end
         end
`endif
         if (byte_ready === 1'b1 && (ready_prev !== 1'b1 || data_out !== data_prev)) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %0h, required no event", data_out);
            end else begin
               e = exp_q.pop_front();
               check("byte_kind", 32'(K_BYTE), 32'(e.kind));
               check("byte_data", 32'(data_out), 32'(e.data));
            end
         end
         ready_prev = byte_ready;
         data_prev  = data_out;
      end
   end

   initial begin : stimulus
      logic [7:0] b;
      logic       stop_bit;
      rst       = 1'b1;
      serial_in = 1'b1;
      byte_ack  = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(1);
      check("reset_data_out", 32'(data_out), 32'h00);
      check("reset_byte_ready", 32'(byte_ready), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      idle(5);

      // Clean frame.
      send_frame(8'hA5, 1'b1, -1);
      idle(2);
      check("a5_ready", 32'(byte_ready), 32'h1);
      check("a5_data", 32'(data_out), 32'hA5);
      check("a5_no_overrun", 32'(overrun), 32'h0);
      ack_pulse();
      check("a5_ack_clears", 32'(byte_ready), 32'h0);
      idle(5);

      // Stop bit low.
      send_frame(8'h3C, 1'b0, -1);
      idle(4);
      check("3c_ready_low", 32'(byte_ready), 32'h0);
      check("3c_data_kept", 32'(data_out), 32'hA5);

      // Frame error with the line then held low: no new frame until high-then-low.
      send_frame(8'h5A, 1'b0, -1);
      serial_in = 1'b0;
      idle(3 * N);
      serial_in = 1'b1;
      idle(N);
      check("held_low_no_byte", 32'(byte_ready), 32'h0);
      send_frame(8'h96, 1'b1, -1);
      idle(2);
      check("after_low_data", 32'(data_out), 32'h96);
      ack_pulse();

      // 5-cycle low glitch on the idle line.
      serial_in = 1'b0;
      idle(5);
      serial_in = 1'b1;
      idle(3 * N);
      check("glitch_no_ready", 32'(byte_ready), 32'h0);
      check("glitch_data_kept", 32'(data_out), 32'h96);

      // Overrun: two bytes, no ack in between.
      send_frame(8'h11, 1'b1, -1);
      idle(3);
      send_frame(8'h22, 1'b1, -1);
      idle(2);
      check("ovr_data", 32'(data_out), 32'h22);
      check("ovr_ready", 32'(byte_ready), 32'h1);
      check("ovr_flag", 32'(overrun), 32'h1);
      ack_pulse();
      check("ovr_ack_ready", 32'(byte_ready), 32'h0);
      check("ovr_sticky", 32'(overrun), 32'h1);
      idle(5);

      // Reset during bit 4 of 0xFF, then a clean 0x0F.
      send_frame(8'hFF, 1'b1, 4);
      idle(3);
      check("rst_mid_overrun", 32'(overrun), 32'h0);
      check("rst_mid_ready", 32'(byte_ready), 32'h0);
      check("rst_mid_data", 32'(data_out), 32'h00);
      send_frame(8'h0F, 1'b1, -1);
      idle(2);
      check("0f_data", 32'(data_out), 32'h0F);
      check("0f_ready", 32'(byte_ready), 32'h1);
      ack_pulse();
      idle(3);

`ifdef UART_RX_PARITY_EN
      par_bad_next = 1'b1;
      send_frame(8'h07, 1'b1, -1);
      par_bad_next = 1'b0;
      idle(3);
      check("par_bad_ready", 32'(byte_ready), 32'h0);
      send_frame(8'h07, 1'b1, -1);
      idle(2);
      check("par_ok_data", 32'(data_out), 32'h07);
      ack_pulse();
      idle(3);
`endif

      // Randomized frames with random acknowledge behaviour.
      model_ready   = 1'b0;
      model_overrun = 1'b0;
      last_data     = data_out;
      for (int n = 0; n < 24; n++) begin
         b        = 8'($urandom_range(0, 255));
         stop_bit = ($urandom_range(0, 4) != 0);
         // A repeat of an unacknowledged byte would be invisible to the monitor.
         if (stop_bit && model_ready && b == last_data) b = b ^ 8'h01;
         send_frame(b, stop_bit, -1);
         idle(2);
         if (stop_bit) begin
            if (model_ready) model_overrun = 1'b1;
            model_ready = 1'b1;
            last_data   = b;
         end
         check("rnd_ready", 32'(byte_ready), 32'(model_ready));
         check("rnd_overrun", 32'(overrun), 32'(model_overrun));
         if ($urandom_range(0, 1) == 1) begin
            ack_pulse();
            model_ready = 1'b0;
            check("rnd_ack_ready", 32'(byte_ready), 32'h0);
         end
         idle($urandom_range(1, 20));
      end

      idle(2 * N);
      check("all_events_seen", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port serial_in  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port data_out  output  8  last received byte.
REQ-006 SHALL have port byte_ready  output  1  high while data_out holds an unconsumed byte.
REQ-007 SHALL have port byte_ack  input  1  consumer acknowledge; clears byte_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 SHALL have port overrun  output  1  sticky flag; a byte completed while byte_ready was high.

Function
REQ-010 SHALL pass serial_in through a two-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-011 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
REQ-012 SHALL leave IDLE for START on a synchronized 1->0 transition; the bit counter resets to 0 on entry.
REQ-013 SHALL, in START, sample the line after CLKS_PER_BIT/2 cycles (integer division): low -> DATA; high -> IDLE with no output change (glitch reject).
REQ-014 SHALL, in DATA, sample every CLKS_PER_BIT cycles; 8 samples, LSB first, shifted into an internal register.
REQ-015 SHALL, in STOP, sample once after CLKS_PER_BIT cycles, then return to IDLE the same cycle.
REQ-016 SHALL, on stop=1, load data_out and set byte_ready on the next clk edge; data_out SHALL not change otherwise.
REQ-017 SHALL, on stop=0, pulse frame_err for one cycle, discard the byte, and leave data_out and byte_ready unchanged.
REQ-018 SHALL clear byte_ready on the cycle after byte_ack is seen high; byte_ack while byte_ready is low has no effect.
REQ-019 SHALL, if a valid byte completes while byte_ready is high and byte_ack is low, overwrite data_out, keep byte_ready high, and set overrun; byte_ack coincident with completion SHALL NOT set overrun.
REQ-020 SHALL clear overrun only on reset.
REQ-021 SHALL ignore serial_in edges outside IDLE; a line held low after a frame error SHALL NOT start a new frame until a high-then-low transition is seen.

Reset
REQ-022 SHALL, on rst high at a clk edge, force state IDLE, counters 0, data_out 8'h00, byte_ready 0, frame_err 0, overrun 0, and both synchronizer flops 1.
REQ-023 SHALL, on reset mid-frame, abandon the frame; the next start needs a fresh falling edge after rst deasserts.

Configuration
REQ-024 SHALL, with UART_RX_PARITY_EN defined, insert a PARITY state between DATA and STOP that samples one even-parity bit, and add output parity_err (1 bit, one-cycle pulse); a mismatched byte SHALL be discarded like a frame error.
REQ-025 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and the parity_err port; frame is 10 bits.

Structure
REQ-026 SHALL take the state enum, DATA_BITS=8, and the shared idle-line level from package uart_pkg, also used by uart_transmitter.
REQ-027 SHALL place the bit-period counter in sub-module uart_baud_counter (restart input, half/full-period tick outputs).

Verification
REQ-028 SHALL cover: CLKS_PER_BIT=16, frame for 8'hA5 (start, 1,0,1,0,0,1,0,1, stop) -> byte_ready rises once, data_out=8'hA5, frame_err=0.
REQ-029 SHALL cover: 8'h3C then stop bit low -> one frame_err pulse, byte_ready stays 0, data_out unchanged.
REQ-030 SHALL cover: 5-cycle low glitch on idle line -> returns to IDLE, no byte_ready, no frame_err.
REQ-031 SHALL cover: 8'h11 then 8'h22 without byte_ack -> data_out=8'h22, byte_ready=1, overrun=1; byte_ack -> byte_ready=0, overrun stays 1.
REQ-032 SHALL cover: rst pulse during bit 4 of 8'hFF, then full 8'h0F frame -> only 8'h0F delivered, no frame_err.
REQ-033 SHALL cover (UART_RX_PARITY_EN): 8'h07 with parity bit 0 -> parity_err pulse, no byte_ready; parity bit 1 -> data_out=8'h07.
